// File: rtl/watches_pkg.sv
// Shared types, BCD limits and field-increment helpers for the watch time-setting path.
package watches_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } set_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t HOUR_MAX_T = 4'd2;
    localparam bcd_t HOUR_MAX_O = 4'd3;
    localparam bcd_t MIN_MAX_T  = 4'd5;
    localparam bcd_t BCD_MAX    = 4'd9;

    // Returns {tens, ones}; 23 and every illegal hour value roll to 00.
    function automatic logic [7:0] hours_inc(input bcd_t t, input bcd_t o);
        if (t > HOUR_MAX_T || o > BCD_MAX || (t == HOUR_MAX_T && o >= HOUR_MAX_O))
            return 8'h00;
        else if (o == BCD_MAX)
            return {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    // Returns {tens, ones}; 59 and every illegal minute value roll to 00.
    function automatic logic [7:0] minutes_inc(input bcd_t t, input bcd_t o);
        if (t > MIN_MAX_T || o > BCD_MAX)
            return 8'h00;
        else if (o == BCD_MAX)
            return (t == MIN_MAX_T) ? 8'h00 : {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter, press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic a_reset_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // press_o rises together with stable on its 0->1 edge, so it is a clean one-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (!a_reset_i) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            stable  <= 1'b0;
            cnt     <= '0;
            press_o <= 1'b0;
        end else begin
            sync1   <= btn_i;
            sync2   <= sync1;
            press_o <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable  <= sync2;
                cnt     <= '0;
                press_o <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven hours/minutes editor sitting in front of the watch counter chain.
module time_set_ctrl
    import watches_pkg::*;
#(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       clk_i,
    input  logic       a_reset_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic [3:0] h_t_i,
    input  logic [3:0] h_o_i,
    input  logic [3:0] m_t_i,
    input  logic [3:0] m_o_i,
    output logic       run_o,
    output logic       load_o,
    output logic [3:0] h_t_o,
    output logic [3:0] h_o_o,
    output logic [3:0] m_t_o,
    output logic [3:0] m_o_o,
    output logic [5:0] blank_o
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic mode_ev;
    logic inc_ev;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk_i     (clk_i),
        .a_reset_i (a_reset_i),
        .btn_i     (btn_mode_i),
        .press_o   (mode_ev)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk_i     (clk_i),
        .a_reset_i (a_reset_i),
        .btn_i     (btn_inc_i),
        .press_o   (inc_ev)
    );

    set_state_t    state_q, state_d;
    logic          run_d, load_d;
    bcd_t          ht_d, ho_d, mt_d, mo_d;
    logic [7:0]    hrs_nxt, min_nxt;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    blank_d;

    always_comb begin
        state_d     = state_q;
        ht_d        = h_t_o;
        ho_d        = h_o_o;
        mt_d        = m_t_o;
        mo_d        = m_o_o;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        blank_d     = '0;
        hrs_nxt     = hours_inc(h_t_o, h_o_o);
        min_nxt     = minutes_inc(m_t_o, m_o_o);

        // Mode is checked first everywhere so a coincident inc press is dropped.
        case (state_q)
            RUN: begin
                // Hold the loaded value through the load cycle; tracking resumes after.
                if (!load_o) begin
                    ht_d = h_t_i;
                    ho_d = h_o_i;
                    mt_d = m_t_i;
                    mo_d = m_o_i;
                end
                if (mode_ev) state_d = SET_H;
            end
            SET_H: begin
                if (mode_ev)     state_d = SET_M;
                else if (inc_ev) {ht_d, ho_d} = hrs_nxt;
            end
            SET_M: begin
                if (mode_ev)     state_d = RUN;
                else if (inc_ev) {mt_d, mo_d} = min_nxt;
            end
            default: state_d = RUN;
        endcase

        load_d = (state_q == SET_M) && mode_ev;
        run_d  = (state_d == RUN);

        // Restart the blink on any edit activity so the field shows immediately.
        if (state_d != state_q || inc_ev) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        if (state_d == SET_H) blank_d[5:4] = {2{phase_d}};
        if (state_d == SET_M) blank_d[3:2] = {2{phase_d}};
    end

    always_ff @(posedge clk_i) begin
        if (!a_reset_i) begin
            state_q     <= RUN;
            run_o       <= 1'b1;
            load_o      <= 1'b0;
            h_t_o       <= '0;
            h_o_o       <= '0;
            m_t_o       <= '0;
            m_o_o       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blank_o     <= '0;
        end else begin
            state_q     <= state_d;
            run_o       <= run_d;
            load_o      <= load_d;
            h_t_o       <= ht_d;
            h_o_o       <= ho_d;
            m_t_o       <= mt_d;
            m_o_o       <= mo_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blank_o     <= blank_d;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: edit-sequence table, press timing, blink, simultaneous presses, reset mid-edit.
module tb_time_set_ctrl;

    localparam int DB = 4;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] h_t_i = '0, h_o_i = '0, m_t_i = '0, m_o_i = '0;
    logic       run_o, load_o;
    logic [3:0] h_t_o, h_o_o, m_t_o, m_o_o;
    logic [5:0] blank_o;

    time_set_ctrl #(.DB_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
        .clk_i      (clk),
        .a_reset_i  (rst_n),
        .btn_mode_i (btn_mode),
        .btn_inc_i  (btn_inc),
        .h_t_i      (h_t_i),
        .h_o_i      (h_o_i),
        .m_t_i      (m_t_i),
        .m_o_i      (m_o_i),
        .run_o      (run_o),
        .load_o     (load_o),
        .h_t_o      (h_t_o),
        .h_o_o      (h_o_o),
        .m_t_o      (m_t_o),
        .m_o_o      (m_o_o),
        .blank_o    (blank_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic load_prev = 1'b0;

    typedef struct {
        logic [15:0] start;
        int          n_h;
        int          n_m;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [15:0] s, input int nh, input int nm, input logic [15:0] e);
        vec_t v;
        v.start = s;
        v.n_h   = nh;
        v.n_m   = nm;
        v.expv  = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Driver tasks
    task automatic press(input bit mode, input bit inc, input int hold);
        @(negedge clk);
        btn_mode = mode;
        btn_inc  = inc;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [15:0] t);
        {h_t_i, h_o_i, m_t_i, m_o_i} = t;
    endtask

    function automatic logic [15:0] shown();
        return {h_t_o, h_o_o, m_t_o, m_o_o};
    endfunction

    // Scoreboard: every load strobe must match the oldest pending expected time.
    always @(negedge clk) begin
        if (rst_n && load_o) begin
            if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
            else                   chk("load_time", shown(), exp_q.pop_front());
            chk("run_at_load", run_o, 1);
            chk("load_one_cycle", load_prev, 0);
        end
        load_prev = load_o;
    end

    initial begin
        int first;
        bit ok;
        logic [5:0] seen;

        vecs[0]  = mk(16'h2200, 2, 0, 16'h0000);
        vecs[1]  = mk(16'h0915, 1, 0, 16'h1015);
        vecs[2]  = mk(16'h1930, 1, 0, 16'h2030);
        vecs[3]  = mk(16'h1259, 0, 1, 16'h1200);
        vecs[4]  = mk(16'h0809, 0, 1, 16'h0810);
        vecs[5]  = mk(16'h2345, 1, 2, 16'h0047);
        vecs[6]  = mk(16'h0A00, 1, 0, 16'h0000);
        vecs[7]  = mk(16'h2510, 1, 0, 16'h0010);
        vecs[8]  = mk(16'h3000, 1, 0, 16'h0000);
        vecs[9]  = mk(16'h1160, 0, 1, 16'h1100);
        vecs[10] = mk(16'h140C, 0, 1, 16'h1400);
        vecs[11] = mk(16'h1234, 0, 0, 16'h1234);
        vecs[12] = mk(16'h1349, 0, 1, 16'h1350);

        // Reset state
        set_inputs(16'h1234);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_run", run_o, 1);
        chk("reset_load", load_o, 0);
        chk("reset_blank", blank_o, 0);
        chk("reset_digits", shown(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("track_after_reset", shown(), 16'h1234);

        // Short mode press is filtered out
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (run_o !== 1'b1 || blank_o !== 6'h00) ok = 1'b0;
        end
        chk("short_press_ignored", ok, 1);

        // Long mode press: enter SET_H, then watch the hours blink
        first = -1;
        btn_mode = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) btn_mode = 1'b0;
            if (first < 0 && run_o == 1'b0) first = i;
            if (first >= 0 && (i - first) < 24)
                chk("blink_set_h", blank_o, (((i - first) / BL) % 2) ? 6'h30 : 6'h00);
        end
        if (first < 0) chk("enter_set_h_timeout", 0, 1);
        else           chk("enter_set_h_latency", (first == DB + 2 || first == DB + 3), 1);
        chk("set_h_frozen", shown(), 16'h1234);
        press(1, 0, 6);
        exp_q.push_back(16'h1234);
        press(1, 0, 6);
        chk("run_after_load", run_o, 1);

        // Edit sequences from the table
        foreach (vecs[v]) begin
            set_inputs(vecs[v].start);
            repeat (2) @(negedge clk);
            chk("track", shown(), vecs[v].start);
            press(1, 0, 6);
            chk("set_h_run", run_o, 0);
            for (int k = 0; k < vecs[v].n_h; k++) press(0, 1, 6);
            chk("hours_edit", {h_t_o, h_o_o}, vecs[v].expv[15:8]);
            press(1, 0, 6);
            for (int k = 0; k < vecs[v].n_m; k++) press(0, 1, 6);
            chk("min_edit", shown(), vecs[v].expv);
            exp_q.push_back(vecs[v].expv);
            press(1, 0, 6);
            chk("run_after_vec", run_o, 1);
        end

        // Mode and inc together in SET_H: mode wins, hours untouched
        set_inputs(16'h0720);
        repeat (2) @(negedge clk);
        press(1, 0, 6);
        press(1, 1, 6);
        chk("simul_hours_kept", shown(), 16'h0720);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seen = seen | blank_o;
        end
        chk("simul_in_set_m_blank", seen, 6'h0C);
        press(0, 1, 6);
        exp_q.push_back(16'h0721);
        press(1, 0, 6);

        // Reset in SET_M: back to RUN, no load
        set_inputs(16'h0505);
        repeat (2) @(negedge clk);
        press(1, 0, 6);
        press(1, 0, 6);
        press(0, 1, 6);
        chk("pre_reset_edit", shown(), 16'h0506);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_reset_run", run_o, 1);
        chk("mid_reset_blank", blank_o, 0);
        ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (load_o !== 1'b0 || run_o !== 1'b1) ok = 1'b0;
        end
        chk("no_load_after_reset", ok, 1);
        chk("track_after_mid_reset", shown(), 16'h0505);

        chk("pending_loads", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
